// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Purpose  : Front-end control for the digital clock time counters.
//            Synchronises and debounces the MODE and UP push buttons, runs
//            the RUN / SET_HOUR / SET_MIN state machine, issues hour/minute
//            increment pulses with auto-repeat, a seconds-clear pulse, a
//            seconds run enable, and a per-digit blink mask.
// Ports    : pCLK       - system clock (rising edge)
//            pRST       - synchronous active-high reset
//            BTN_MODE   - raw mode button, 0 = pressed
//            BTN_UP     - raw increment button, 0 = pressed
//            SET_MODE   - 00 RUN, 01 SET_HOUR, 10 SET_MIN
//            RUN_EN     - high only in RUN
//            INC_HOUR   - one-cycle hour increment pulse
//            INC_MIN    - one-cycle minute increment pulse
//            SEC_CLR    - one-cycle seconds clear pulse
//            BLINK_MASK - per-digit blank request (bit3 hour tens .. bit0 min ones)
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int DEB_CYCLES   = 400000,
    parameter int REPEAT_DELAY = 4000000,
    parameter int REPEAT_RATE  = 1600000,
    parameter int BLINK_HALF   = 2000000
) (
    input  logic       pCLK,
    input  logic       pRST,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    output logic [1:0] SET_MODE,
    output logic       RUN_EN,
    output logic       INC_HOUR,
    output logic       INC_MIN,
    output logic       SEC_CLR,
    output logic [3:0] BLINK_MASK
);

    localparam int DEB_W   = $clog2(DEB_CYCLES) + 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam int BLK_W   = $clog2(BLINK_HALF) + 1;
    localparam int NBTN    = 2;

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOUR = 2'b01,
        ST_MIN  = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = MODE, index 1 = UP.
    // held  : debounced level, 1 = pressed
    // press : one-cycle released->pressed event
    // ------------------------------------------------------------------
    logic [NBTN-1:0] raw_btn;
    logic [NBTN-1:0] btn_held;
    logic [NBTN-1:0] btn_press;

    assign raw_btn = {BTN_UP, BTN_MODE};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic             sync1;
            logic             sync2;
            logic             deb;
            logic             deb_d;
            logic [DEB_W-1:0] cnt;

            always_ff @(posedge pCLK) begin
                if (pRST) begin
                    sync1 <= 1'b1;
                    sync2 <= 1'b1;
                    deb   <= 1'b0;
                    deb_d <= 1'b0;
                    cnt   <= '0;
                end else begin
                    sync1 <= raw_btn[gi];
                    sync2 <= sync1;
                    deb_d <= deb;
                    // Raw buttons are active-low; deb holds the pressed level.
                    if (~sync2 == deb) begin
                        cnt <= '0;
                    end else if (cnt >= DEB_LAST) begin
                        deb <= ~sync2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign btn_held[gi]  = deb;
            assign btn_press[gi] = deb & ~deb_d;
        end
    endgenerate

    logic mode_press;
    logic up_press;
    logic up_held;

    assign mode_press = btn_press[0];
    assign up_press   = btn_press[1];
    assign up_held    = btn_held[1];

    // ------------------------------------------------------------------
    // Control state and next-state logic
    // ------------------------------------------------------------------
    state_t           state;
    logic             rep_act;     // repeat sequence armed by a first pulse
    logic             rep_rate;    // 0: waiting REPEAT_DELAY, 1: REPEAT_RATE
    logic [REP_W-1:0] rep_cnt;
    logic             phase;
    logic [BLK_W-1:0] blk_cnt;

    state_t           state_nxt;
    logic             rep_act_nxt;
    logic             rep_rate_nxt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             phase_nxt;
    logic [BLK_W-1:0] blk_cnt_nxt;
    logic             inc_any;
    logic             sec_clr_nxt;
    logic [3:0]       mask_nxt;

    always_comb begin
        state_nxt    = state;
        rep_act_nxt  = rep_act;
        rep_rate_nxt = rep_rate;
        rep_cnt_nxt  = rep_cnt;
        inc_any      = 1'b0;
        sec_clr_nxt  = 1'b0;

        if (mode_press) begin
            // A mode change wins over any coincident UP event.
            case (state)
                ST_RUN:  state_nxt = ST_HOUR;
                ST_HOUR: state_nxt = ST_MIN;
                ST_MIN: begin
                    state_nxt   = ST_RUN;
                    sec_clr_nxt = 1'b1;
                end
                default: state_nxt = ST_RUN;
            endcase
            rep_act_nxt  = 1'b0;
            rep_rate_nxt = 1'b0;
            rep_cnt_nxt  = '0;
        end else if (!up_held || state == ST_RUN) begin
            rep_act_nxt  = 1'b0;
            rep_rate_nxt = 1'b0;
            rep_cnt_nxt  = '0;
        end else if (up_press) begin
            inc_any      = 1'b1;
            rep_act_nxt  = 1'b1;
            rep_rate_nxt = 1'b0;
            rep_cnt_nxt  = '0;
        end else if (rep_act) begin
            // Counter restarts on every pulse, so it never reaches wrap.
            if (rep_cnt >= (rep_rate ? RATE_LAST : DELAY_LAST)) begin
                inc_any      = 1'b1;
                rep_rate_nxt = 1'b1;
                rep_cnt_nxt  = '0;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end

        // Blink phase restarts visible whenever the user acts.
        if (mode_press || inc_any) begin
            phase_nxt   = 1'b0;
            blk_cnt_nxt = '0;
        end else if (blk_cnt >= BLINK_LAST) begin
            phase_nxt   = ~phase;
            blk_cnt_nxt = '0;
        end else begin
            phase_nxt   = phase;
            blk_cnt_nxt = blk_cnt + 1'b1;
        end

        mask_nxt = 4'b0000;
        if (phase_nxt && state_nxt == ST_HOUR) begin
            mask_nxt = 4'b1100;
        end else if (phase_nxt && state_nxt == ST_MIN) begin
            mask_nxt = 4'b0011;
        end
    end

    always_ff @(posedge pCLK) begin
        if (pRST) begin
            state      <= ST_RUN;
            rep_act    <= 1'b0;
            rep_rate   <= 1'b0;
            rep_cnt    <= '0;
            phase      <= 1'b0;
            blk_cnt    <= '0;
            RUN_EN     <= 1'b1;
            INC_HOUR   <= 1'b0;
            INC_MIN    <= 1'b0;
            SEC_CLR    <= 1'b0;
            BLINK_MASK <= 4'b0000;
        end else begin
            state      <= state_nxt;
            rep_act    <= rep_act_nxt;
            rep_rate   <= rep_rate_nxt;
            rep_cnt    <= rep_cnt_nxt;
            phase      <= phase_nxt;
            blk_cnt    <= blk_cnt_nxt;
            RUN_EN     <= (state_nxt == ST_RUN);
            INC_HOUR   <= inc_any && (state == ST_HOUR);
            INC_MIN    <= inc_any && (state == ST_MIN);
            SEC_CLR    <= sec_clr_nxt;
            BLINK_MASK <= mask_nxt;
        end
    end

    assign SET_MODE = state;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Purpose  : Self-checking bench for clock_set_ctrl. A reference model of the
//            button/mode/repeat/blink rules predicts every cycle's outputs
//            into a queue; a monitor pops and compares after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 5;
    localparam int BH  = 8;
    localparam int HL  = DEB + 2;

    logic       pCLK;
    logic       pRST;
    logic       BTN_MODE;
    logic       BTN_UP;
    logic [1:0] SET_MODE;
    logic       RUN_EN;
    logic       INC_HOUR;
    logic       INC_MIN;
    logic       SEC_CLR;
    logic [3:0] BLINK_MASK;

    clock_set_ctrl #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .BLINK_HALF  (BH)
    ) dut (
        .pCLK      (pCLK),
        .pRST      (pRST),
        .BTN_MODE  (BTN_MODE),
        .BTN_UP    (BTN_UP),
        .SET_MODE  (SET_MODE),
        .RUN_EN    (RUN_EN),
        .INC_HOUR  (INC_HOUR),
        .INC_MIN   (INC_MIN),
        .SEC_CLR   (SEC_CLR),
        .BLINK_MASK(BLINK_MASK)
    );

    initial pCLK = 1'b0;
    always #5 pCLK = ~pCLK;

    typedef struct packed {
        logic [1:0] mode;
        logic       run_en;
        logic       inc_h;
        logic       inc_m;
        logic       sclr;
        logic [3:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hour_seen = 0;
    int   min_seen  = 0;
    int   clr_seen  = 0;

    // ---------------- reference model state ----------------
    int          t_edge = 0;
    int          m_mode;
    logic        mdeb, mdeb_p, udeb, udeb_p;
    logic [HL-1:0] mh, uh;   // per-edge pressed samples, bit 0 newest
    int          rep_first;  // edge of first UP pulse, -1 when none
    int          anchor;     // edge where blink phase last restarted

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Predict outputs visible after the coming edge given the sampled inputs.
    task automatic model_edge(input logic bm, input logic bu, input logic r);
        exp_t e;
        logic pm, pu, held, fm, fu, pulse, sclr;
        int   k, ph;
        pulse = 1'b0;
        sclr  = 1'b0;
        if (r) begin
            m_mode = 0; mdeb = 0; mdeb_p = 0; udeb = 0; udeb_p = 0;
            mh = '0; uh = '0; rep_first = -1; anchor = t_edge;
        end else begin
            pm   = mdeb & ~mdeb_p;
            pu   = udeb & ~udeb_p;
            held = udeb;
            // Level is accepted once the synchronised button (two edges
            // old) has disagreed with it for DEB consecutive edges.
            mh = {mh[HL-2:0], ~bm};
            uh = {uh[HL-2:0], ~bu};
            fm = 1'b1;
            fu = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) begin
                if (mh[j] == mdeb) fm = 1'b0;
                if (uh[j] == udeb) fu = 1'b0;
            end
            mdeb_p = mdeb;
            udeb_p = udeb;
            if (fm) mdeb = ~mdeb;
            if (fu) udeb = ~udeb;

            if (pm) begin
                sclr      = (m_mode == 2);
                m_mode    = (m_mode + 1) % 3;
                rep_first = -1;
                anchor    = t_edge;
            end else if (!held || m_mode == 0) begin
                rep_first = -1;
            end else if (pu) begin
                pulse     = 1'b1;
                rep_first = t_edge;
            end else if (rep_first >= 0) begin
                k = t_edge - rep_first;
                if (k == RD || (k > RD && (k - RD) % RR == 0)) pulse = 1'b1;
            end
            if (pulse) anchor = t_edge;
        end
        ph       = ((t_edge - anchor) / BH) % 2;
        e.mode   = 2'(m_mode);
        e.run_en = (m_mode == 0);
        e.inc_h  = pulse && m_mode == 1;
        e.inc_m  = pulse && m_mode == 2;
        e.sclr   = sclr;
        e.mask   = (ph == 1 && m_mode == 1) ? 4'b1100 :
                   (ph == 1 && m_mode == 2) ? 4'b0011 : 4'b0000;
        exp_q.push_back(e);
        t_edge++;
    endtask

    task automatic step(input logic bm, input logic bu, input logic r);
        @(negedge pCLK);
        BTN_MODE = bm;
        BTN_UP   = bu;
        pRST     = r;
        model_edge(bm, bu, r);
    endtask

    task automatic hold(input logic bm, input logic bu, input int n);
        for (int i = 0; i < n; i++) step(bm, bu, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge pCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("set_mode", {2'b00, SET_MODE}, {2'b00, e.mode});
                chk("run_en", {3'b000, RUN_EN}, {3'b000, e.run_en});
                chk("pulses", {1'b0, INC_HOUR, INC_MIN, SEC_CLR}, {1'b0, e.inc_h, e.inc_m, e.sclr});
                chk("blink_mask", BLINK_MASK, e.mask);
                if (INC_HOUR) hour_seen++;
                if (INC_MIN)  min_seen++;
                if (SEC_CLR)  clr_seen++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int h0, m0, c0;
        int len;
        logic rm, ru;
        BTN_MODE = 1'b1;
        BTN_UP   = 1'b1;
        pRST     = 1'b1;

        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 50);

        // Short MODE glitch, then a real press into SET_HOUR.
        hold(1'b0, 1'b1, 2);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);

        // Held UP in SET_HOUR: first pulse plus repeats at +20,+25,+30,+35.
        h0 = hour_seen; m0 = min_seen;
        hold(1'b1, 1'b0, 40);
        hold(1'b1, 1'b1, 15);
        chk("hold_hour_pulses", 4'(hour_seen - h0), 4'd5);
        chk("hold_min_pulses", 4'(min_seen - m0), 4'd0);

        // Into SET_MIN, let it blink, then an UP press restarts the phase.
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 30);
        hold(1'b1, 1'b0, 8);
        hold(1'b1, 1'b1, 20);

        // Back to RUN (seconds clear), then into SET_HOUR again.
        c0 = clr_seen;
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        chk("sec_clr_count", 4'(clr_seen - c0), 4'd1);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);

        // Simultaneous MODE and UP press: mode change only.
        h0 = hour_seen; m0 = min_seen;
        hold(1'b0, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        chk("simul_inc_pulses", 4'(hour_seen + min_seen - h0 - m0), 4'd0);

        // Reset while UP is held in SET_MIN.
        hold(1'b1, 1'b0, 12);
        step(1'b1, 1'b0, 1'b1);
        m0 = min_seen;
        hold(1'b1, 1'b0, 30);
        hold(1'b1, 1'b1, 10);
        chk("post_reset_min_pulses", 4'(min_seen - m0), 4'd0);

        // Randomised button activity with occasional resets.
        for (int s = 0; s < 120; s++) begin
            rm  = 1'($urandom_range(0, 1));
            ru  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 60)
                                              : $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) step(rm, ru, 1'b1);
            hold(rm, ru, len);
        end
        hold(1'b1, 1'b1, 20);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge pCLK);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
